// File: rtl/tdp_ram_pkg.sv
// Shared types and constants for the initialising true-dual-port RAM.
package tdp_ram_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  // Saturating 8-bit increment used by the collision event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/tdp_ram_port.sv
// Per-port read-data / valid pipeline; OUT_REG=1 appends a second stage.
module tdp_ram_port
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] q_o,
  output logic              vld_o
);

  logic              s1_vld_q;
  logic [DATA_W-1:0] s1_dat_q;

  // First stage: capture array output on every accepted access, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= {DATA_W{1'b0}};
    end else begin
      s1_vld_q <= acc_i;
      if (acc_i) begin
        s1_dat_q <= rdata_i;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s2_vld_q;
      logic [DATA_W-1:0] s2_dat_q;

      // Second stage only advances when stage one presents a result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= {DATA_W{1'b0}};
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) begin
            s2_dat_q <= s1_dat_q;
          end
        end
      end

      assign q_o   = s2_dat_q;
      assign vld_o = s2_vld_q;
    end else begin : g_noreg
      assign q_o   = s1_dat_q;
      assign vld_o = s1_vld_q;
    end
  endgenerate

endmodule

// File: rtl/tdp_ram_init.sv
// True-dual-port RAM that zero-fills itself after reset before accepting accesses.
// Optional feature macro: TDP_RAM_COLLISION_EN adds collision / coll_cnt outputs.
module tdp_ram_init
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int OUT_REG = 0,
  parameter int WR_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  output logic              vld_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              vld_b,
  output logic              ready
`ifdef TDP_RAM_COLLISION_EN
  ,
  output logic              collision,
  output logic [7:0]        coll_cnt
`endif
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic              run;
  logic              acc_a, acc_b, wr_a, wr_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  assign run   = (state_q == RUN);
  assign acc_a = run & en_a;
  assign acc_b = run & en_b;
  assign wr_a  = acc_a & we_a;
  assign wr_b  = acc_b & we_b;

  // Next-state logic: walk the clear counter through every address, then run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = {ADDR_W{1'b0}};
          ready_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          ready_d = 1'b0;
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = INIT;
        cnt_d   = {ADDR_W{1'b0}};
        ready_d = 1'b0;
      end
    endcase
  end

  // FSM, clear counter and ready flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= {ADDR_W{1'b0}};
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage array; port A is written last so it wins a same-address write clash.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= {DATA_W{1'b0}};
    end else begin
      if (wr_b) begin
        mem_q[addr_b] <= data_b;
      end
      if (wr_a) begin
        mem_q[addr_a] <= data_a;
      end
    end
  end

  // Read data selection; the opposite port always sees pre-edge contents.
  always_comb begin
    if ((WR_MODE == WRITE_FIRST) && we_a) begin
      rdata_a = data_a;
    end else begin
      rdata_a = mem_q[addr_a];
    end
    if ((WR_MODE == WRITE_FIRST) && we_b) begin
      rdata_b = data_b;
    end else begin
      rdata_b = mem_q[addr_b];
    end
  end

  tdp_ram_port #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_i   (acc_a),
    .rdata_i (rdata_a),
    .q_o     (q_a),
    .vld_o   (vld_a)
  );

  tdp_ram_port #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_i   (acc_b),
    .rdata_i (rdata_b),
    .q_o     (q_b),
    .vld_o   (vld_b)
  );

  assign ready = ready_q;

`ifdef TDP_RAM_COLLISION_EN
  logic       coll_hit;
  logic       collision_q;
  logic [7:0] coll_cnt_q;

  assign coll_hit = acc_a & acc_b & (addr_a == addr_b) & (we_a | we_b);

  // Collision strobe and saturating event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
      coll_cnt_q  <= 8'd0;
    end else begin
      collision_q <= coll_hit;
      if (coll_hit) begin
        coll_cnt_q <= sat_inc8(coll_cnt_q);
      end
    end
  end

  assign collision = collision_q;
  assign coll_cnt  = coll_cnt_q;
`endif

endmodule

// File: tb/tb_tdp_ram_init.sv
// Self-checking bench: two configurations (RF/no-outreg and WF/outreg) driven in lock-step.
module tb_tdp_ram_init;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_a, we_a, en_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] q_a [2];
  logic [DW-1:0] q_b [2];
  logic          vld_a [2];
  logic          vld_b [2];
  logic          ready [2];
`ifdef TDP_RAM_COLLISION_EN
  logic          collision [2];
  logic [7:0]    coll_cnt [2];
`endif

  always #5 clk = ~clk;

  tdp_ram_init #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .WR_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[0]), .vld_a(vld_a[0]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[0]), .vld_b(vld_b[0]),
    .ready(ready[0])
`ifdef TDP_RAM_COLLISION_EN
    , .collision(collision[0]), .coll_cnt(coll_cnt[0])
`endif
  );

  tdp_ram_init #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .WR_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[1]), .vld_a(vld_a[1]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[1]), .vld_b(vld_b[1]),
    .ready(ready[1])
`ifdef TDP_RAM_COLLISION_EN
    , .collision(collision[1]), .coll_cnt(coll_cnt[1])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: memory image, cycles of clearing left, result calendar.
  logic [DW-1:0] mem_m [DEPTH];
  int            init_left;
  int            cyc;
  logic          res_v [2][2][4];
  logic [DW-1:0] res_d [2][2][4];
  logic          exp_v [2][2];
  logic [DW-1:0] exp_q [2][2];
  logic          exp_ready;
  logic          exp_coll;
  int            exp_cnt;

  typedef struct packed {
    logic          ea, wa; logic [AW-1:0] aa; logic [DW-1:0] da;
    logic          eb, wb; logic [AW-1:0] ab; logic [DW-1:0] db;
    logic          v0a; logic [DW-1:0] q0a; logic v0b; logic [DW-1:0] q0b;
    logic          v1a; logic [DW-1:0] q1a; logic v1b; logic [DW-1:0] q1b;
    logic          coll; logic [7:0] cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_left = DEPTH;
    cyc       = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        exp_v[k][p] = 1'b0;
        exp_q[k][p] = '0;
        for (int s = 0; s < 4; s++) begin
          res_v[k][p][s] = 1'b0;
          res_d[k][p][s] = '0;
        end
      end
    exp_ready = 1'b0;
    exp_coll  = 1'b0;
    exp_cnt   = 0;
  endtask

  task automatic sched(input int k, input int p, input logic [DW-1:0] d);
    int slot;
    slot = (cyc + ((k == 0) ? 1 : 2) - 1) % 4;
    res_v[k][p][slot] = 1'b1;
    res_d[k][p][slot] = d;
  endtask

  // Model what a clock edge does, using the inputs currently applied.
  task automatic model_edge();
    logic [DW-1:0] old_a, old_b;
    int slot;
    if (rst_n !== 1'b1) return;
    cyc++;
    exp_coll = 1'b0;
    if (init_left > 0) begin
      init_left--;
    end else begin
      old_a = mem_m[addr_a];
      old_b = mem_m[addr_b];
      for (int k = 0; k < 2; k++) begin
        if (en_a) sched(k, 0, (k == 1 && we_a) ? data_a : old_a);
        if (en_b) sched(k, 1, (k == 1 && we_b) ? data_b : old_b);
      end
      if (en_a && en_b && addr_a == addr_b && (we_a || we_b)) begin
        exp_coll = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
      if (en_b && we_b) mem_m[addr_b] = data_b;
      if (en_a && we_a) mem_m[addr_a] = data_a;
    end
    slot = cyc % 4;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        exp_v[k][p] = res_v[k][p][slot];
        if (res_v[k][p][slot]) exp_q[k][p] = res_d[k][p][slot];
        res_v[k][p][slot] = 1'b0;
      end
    exp_ready = (init_left == 0);
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), ready[k], exp_ready);
      chk($sformatf("vld_a%0d", k), vld_a[k], exp_v[k][0]);
      chk($sformatf("q_a%0d", k),   q_a[k],   exp_q[k][0]);
      chk($sformatf("vld_b%0d", k), vld_b[k], exp_v[k][1]);
      chk($sformatf("q_b%0d", k),   q_b[k],   exp_q[k][1]);
`ifdef TDP_RAM_COLLISION_EN
      chk($sformatf("collision%0d", k), collision[k], exp_coll);
      chk($sformatf("coll_cnt%0d", k),  coll_cnt[k],  exp_cnt);
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    en_a = ea; we_a = wa; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db;
  endtask

  // Count edges from reset release until ready is seen; must be exactly DEPTH.
  task automatic wait_ready(input string nm);
    int  edges;
    bit  seen;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle();
      edges++;
      if (ready[0] === 1'b1 && ready[1] === 1'b1) seen = 1'b1;
    end
    chk(nm, edges, DEPTH);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
    else return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    //          ea wa aa     da     eb wb ab     db     v0a q0a    v0b q0b    v1a q1a    v1b q1b    col cnt
    tbl[0]  = '{1, 0, 6'h3F, 8'h00, 0, 0, 6'h00, 8'h00, 1, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'd0};
    tbl[1]  = '{1, 1, 6'h01, 8'h33, 1, 1, 6'h02, 8'h44, 1, 8'h00, 1, 8'h00, 1, 8'h00, 0, 8'h00, 0, 8'd0};
    tbl[2]  = '{1, 0, 6'h02, 8'h00, 1, 0, 6'h01, 8'h00, 1, 8'h44, 1, 8'h33, 1, 8'h33, 1, 8'h44, 0, 8'd0};
    tbl[3]  = '{1, 1, 6'h02, 8'h55, 1, 1, 6'h02, 8'h77, 1, 8'h44, 1, 8'h44, 1, 8'h44, 1, 8'h33, 1, 8'd1};
    tbl[4]  = '{1, 0, 6'h02, 8'h00, 0, 0, 6'h00, 8'h00, 1, 8'h55, 0, 8'h44, 1, 8'h55, 1, 8'h77, 0, 8'd1};
    tbl[5]  = '{1, 1, 6'h05, 8'h99, 0, 0, 6'h00, 8'h00, 1, 8'h00, 0, 8'h44, 1, 8'h55, 0, 8'h77, 0, 8'd1};
    tbl[6]  = '{1, 0, 6'h05, 8'h00, 1, 0, 6'h3F, 8'h00, 1, 8'h99, 1, 8'h00, 1, 8'h99, 0, 8'h77, 0, 8'd1};
    tbl[7]  = '{0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 8'h99, 0, 8'h00, 1, 8'h99, 1, 8'h00, 0, 8'd1};
    tbl[8]  = '{0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 8'h99, 0, 8'h00, 0, 8'h99, 0, 8'h00, 0, 8'd1};
    tbl[9]  = '{1, 1, 6'h02, 8'h11, 1, 0, 6'h02, 8'h00, 1, 8'h55, 1, 8'h55, 0, 8'h99, 0, 8'h00, 1, 8'd2};
    tbl[10] = '{0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 8'h55, 0, 8'h55, 1, 8'h11, 1, 8'h55, 0, 8'd2};

    rst_n = 1'b0;
    model_reset();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (3) cycle();
    rst_n = 1'b1;
    wait_ready("init_len");

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].ea, tbl[i].wa, tbl[i].aa, tbl[i].da, tbl[i].eb, tbl[i].wb, tbl[i].ab, tbl[i].db);
      cycle();
      chk($sformatf("tbl%0d vld_a0", i), vld_a[0], tbl[i].v0a);
      chk($sformatf("tbl%0d q_a0", i),   q_a[0],   tbl[i].q0a);
      chk($sformatf("tbl%0d vld_b0", i), vld_b[0], tbl[i].v0b);
      chk($sformatf("tbl%0d q_b0", i),   q_b[0],   tbl[i].q0b);
      chk($sformatf("tbl%0d vld_a1", i), vld_a[1], tbl[i].v1a);
      chk($sformatf("tbl%0d q_a1", i),   q_a[1],   tbl[i].q1a);
      chk($sformatf("tbl%0d vld_b1", i), vld_b[1], tbl[i].v1b);
      chk($sformatf("tbl%0d q_b1", i),   q_b[1],   tbl[i].q1b);
`ifdef TDP_RAM_COLLISION_EN
      chk($sformatf("tbl%0d collision", i), collision[0], tbl[i].coll);
      chk($sformatf("tbl%0d coll_cnt", i),  coll_cnt[0],  tbl[i].cnt);
`endif
    end

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), rnd_addr(), DW'($urandom_range(0, 255)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 1), rnd_addr(), DW'($urandom_range(0, 255)));
      cycle();
    end

    // Reset while a read is still travelling through the two-stage pipeline.
    drive(1, 1, 6'h01, 8'h33, 0, 0, 6'h00, 8'h00);
    cycle();
    drive(1, 0, 6'h01, 8'h00, 0, 0, 6'h00, 8'h00);
    cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    drive(1, 0, 6'h01, 8'h00, 1, 1, 6'h01, 8'hAA);
    repeat (2) cycle();
    rst_n = 1'b1;
    wait_ready("reinit_len");
    drive(1, 0, 6'h01, 8'h00, 0, 0, 6'h00, 8'h00);
    cycle();
    chk("reclr vld_a0", vld_a[0], 1'b1);
    chk("reclr q_a0",   q_a[0],   8'h00);
    drive(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00);
    cycle();
    chk("reclr vld_a1", vld_a[1], 1'b1);
    chk("reclr q_a1",   q_a[1],   8'h00);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
